alu_cmd_sequencer: RTL and testbench

Command-side initiator for the 8-bit ALU. It accepts operation commands over a valid/ready stream and buffers them in a small FIFO. It drives the ALU operand/op-code inputs and waits out the ALU's one-cycle registered latency. It then captures Result/C_out/Z_flag and returns a tagged response over a second valid/ready stream. It sits between the test/host command source and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_seq_fifo.sv | 58 +++++
 rtl/alu_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and helpers for the ALU command sequencer
// Purpose: op-code and FSM state enums, the queued command record, and the
// op legality check used when a command leaves the FIFO.
// Ports: none (package).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    RESP
  } seq_state_e;

  localparam logic [3:0] OP_LAST = 4'd5;

  // Width of the tag field held in the command queue.
  localparam int SEQ_TAG_W = 4;

  typedef struct packed {
    logic [3:0]           op;
    logic [7:0]           a;
    logic [7:0]           b;
    logic                 cin;
    logic [SEQ_TAG_W-1:0] tag;
  } alu_cmd_t;

  // A command may reach the ALU only if its op exists and it is not a divide by zero.
  function automatic logic op_issuable(input logic [3:0] op, input logic [7:0] b);
    return (op <= OP_LAST) && !((op == OP_DIV) && (b == 8'd0));
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// rtl/alu_seq_fifo.sv - synchronous command FIFO for the ALU sequencer
// Purpose: DEPTH-entry FIFO of alu_cmd_t with occupancy count and flags.
// Ports: CLk, Reset_n (async active-low); push/push_cmd write side;
// pop/pop_cmd read side (pop_cmd shows the head while !empty);
// full, empty, count status.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLk,
  input  logic                   Reset_n,
  input  logic                   push,
  input  alu_cmd_t               push_cmd,
  input  logic                   pop,
  output alu_cmd_t               pop_cmd,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_cmd = mem[rd_ptr];

  always_ff @(posedge CLk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge CLk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command-side initiator for the 8-bit ALU
// Purpose: queue tagged commands, issue each to the registered ALU, wait out
// its one-cycle latency, and return the captured result or a rejection.
// Ports: CLk, Reset_n (async active-low); cmd_* command stream in
// (cmd_ready = FIFO not full); rsp_* response stream out; alu_A/alu_B/
// alu_op_code/alu_C_in to the ALU; alu_Result/alu_C_out/alu_Z_flag from it.
// Optional: ALU_SEQ_STATS_EN adds stat_issued/stat_errors (16-bit, wrapping).
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = SEQ_TAG_W
) (
  input  logic             CLk,
  input  logic             Reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_cin,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic             rsp_c_out,
  output logic             rsp_z,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]      stat_issued,
  output logic [15:0]      stat_errors,
`endif
  output logic [7:0]       alu_A,
  output logic [7:0]       alu_B,
  output logic [3:0]       alu_op_code,
  output logic             alu_C_in,
  input  logic [15:0]      alu_Result,
  input  logic             alu_C_out,
  input  logic             alu_Z_flag
);

  seq_state_e state, state_nxt;

  alu_cmd_t push_cmd;
  alu_cmd_t pop_cmd;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;
  logic     issue;
  logic     reject;
  logic     capture;
  logic [$clog2(DEPTH):0] fifo_level_unused;

  assign push_cmd  = '{op: cmd_op, a: cmd_a, b: cmd_b, cin: cmd_cin, tag: SEQ_TAG_W'(cmd_tag)};
  assign cmd_ready = !fifo_full;
  assign rsp_valid = (state == RESP);

  alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLk      (CLk),
    .Reset_n  (Reset_n),
    .push     (cmd_valid && cmd_ready),
    .push_cmd (push_cmd),
    .pop      (pop),
    .pop_cmd  (pop_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_level_unused)
  );

  always_ff @(posedge CLk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    reject    = 1'b0;
    capture   = 1'b0;
    case (state)
      // IDLE and a completed response handshake both take the next command.
      IDLE, RESP: begin
        if (state == IDLE || rsp_ready) begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (op_issuable(pop_cmd.op, pop_cmd.b)) begin
              issue     = 1'b1;
              state_nxt = DRIVE;
            end else begin
              reject    = 1'b1;
              state_nxt = RESP;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DRIVE:   state_nxt = SAMPLE;
      SAMPLE: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLk or negedge Reset_n) begin
    if (!Reset_n) begin
      alu_A       <= '0;
      alu_B       <= '0;
      alu_op_code <= '0;
      alu_C_in    <= 1'b0;
      rsp_result  <= '0;
      rsp_c_out   <= 1'b0;
      rsp_z       <= 1'b1;
      rsp_err     <= 1'b0;
      rsp_tag     <= '0;
    end else begin
      if (issue) begin
        alu_A       <= pop_cmd.a;
        alu_B       <= pop_cmd.b;
        alu_op_code <= pop_cmd.op;
        alu_C_in    <= pop_cmd.cin;
        rsp_tag     <= TAG_W'(pop_cmd.tag);
      end
      if (reject) begin
        rsp_result <= '0;
        rsp_c_out  <= 1'b0;
        rsp_z      <= 1'b1;
        rsp_err    <= 1'b1;
        rsp_tag    <= TAG_W'(pop_cmd.tag);
      end
      if (capture) begin
        rsp_result <= alu_Result;
        rsp_z      <= alu_Z_flag;
        // The ALU only refreshes C_out on ADD; any other op leaves it stale.
        rsp_c_out  <= (alu_op_code == OP_ADD) && alu_C_out;
        rsp_err    <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge CLk or negedge Reset_n) begin
    if (!Reset_n) begin
      stat_issued <= '0;
      stat_errors <= '0;
    end else begin
      if (issue)  stat_issued <= stat_issued + 16'd1;
      if (reject) stat_errors <= stat_errors + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

  logic        CLk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic        cmd_cin = 1'b0;
  logic [3:0]  cmd_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic        rsp_c_out;
  logic        rsp_z;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic [3:0]  alu_op_code;
  logic        alu_C_in;
  logic [15:0] alu_Result = '0;
  logic        alu_C_out = 1'b0;
  logic        alu_Z_flag = 1'b1;
  logic [15:0] alu_r;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_errors;
`endif

  int total = 0;
  int bad = 0;

  always #5 CLk = ~CLk;

  alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
    .CLk         (CLk),
    .Reset_n     (Reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_cin     (cmd_cin),
    .cmd_tag     (cmd_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_c_out   (rsp_c_out),
    .rsp_z       (rsp_z),
    .rsp_err     (rsp_err),
    .rsp_tag     (rsp_tag),
`ifdef ALU_SEQ_STATS_EN
    .stat_issued (stat_issued),
    .stat_errors (stat_errors),
`endif
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_op_code (alu_op_code),
    .alu_C_in    (alu_C_in),
    .alu_Result  (alu_Result),
    .alu_C_out   (alu_C_out),
    .alu_Z_flag  (alu_Z_flag)
  );

  // 8-bit ALU stand-in: one-cycle registered, operands zero-extended to 16 bits,
  // C_out refreshed only by ADD.
  always @(posedge CLk) begin
    case (alu_op_code)
      4'd0:    alu_r = {8'h00, alu_A} + {8'h00, alu_B} + {15'd0, alu_C_in};
      4'd1:    alu_r = {8'h00, alu_A} - {8'h00, alu_B};
      4'd2:    alu_r = {8'h00, alu_A} * {8'h00, alu_B};
      4'd3:    alu_r = (alu_B == 8'd0) ? 16'h0000 : {8'h00, alu_A} / {8'h00, alu_B};
      4'd4:    alu_r = {8'h00, alu_A & alu_B};
      4'd5:    alu_r = {8'h00, alu_A ^ alu_B};
      default: alu_r = 16'h0000;
    endcase
    alu_Result <= alu_r;
    alu_Z_flag <= (alu_r == 16'h0000);
    if (alu_op_code == 4'd0) alu_C_out <= alu_r[8];
  end

  typedef struct packed {
    logic [15:0] result;
    logic        c;
    logic        z;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected response for a command, straight from the op definitions.
  function automatic exp_t predict(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic [3:0] tag);
    exp_t e;
    int   r;
    e.tag = tag;
    e.err = 1'b0;
    e.c   = 1'b0;
    r     = 0;
    case (op)
      4'd0: begin
        r   = int'(a) + int'(b) + int'(cin);
        e.c = (r > 255);
      end
      4'd1: r = int'(a) - int'(b);
      4'd2: r = int'(a) * int'(b);
      4'd3: if (b != 8'd0) r = int'(a) / int'(b); else e.err = 1'b1;
      4'd4: r = int'(a & b);
      4'd5: r = int'(a ^ b);
      default: e.err = 1'b1;
    endcase
    e.result = e.err ? 16'h0000 : 16'(r);
    e.z      = (e.result == 16'h0000);
    return e;
  endfunction

  // Reference compare: every cycle a response is presented it must match the
  // oldest outstanding command; accepted commands join the queue.
  always @(negedge CLk) begin
    exp_t e;
    if (!Reset_n) begin
      exp_q.delete();
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q[0];
          chk("m_result", 32'(rsp_result), 32'(e.result));
          chk("m_c_out", 32'(rsp_c_out), 32'(e.c));
          chk("m_z", 32'(rsp_z), 32'(e.z));
          chk("m_err", 32'(rsp_err), 32'(e.err));
          chk("m_tag", 32'(rsp_tag), 32'(e.tag));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(predict(cmd_op, cmd_a, cmd_b, cmd_cin, cmd_tag));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [3:0] tag);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_tag = tag;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 60) begin
      @(posedge CLk); #1;
      n++;
    end
    if (n >= 60) chk("push_timeout", 32'd1, 32'd0);
    @(posedge CLk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      @(posedge CLk); #1;
      lat++;
    end
    if (lat >= 60) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag_s);
    chk({tag_s, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag_s, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag_s, "_rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag_s, "_rsp_c_out"}, 32'(rsp_c_out), 32'd0);
    chk({tag_s, "_rsp_z"}, 32'(rsp_z), 32'd1);
    chk({tag_s, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag_s, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
    chk({tag_s, "_alu_A"}, 32'(alu_A), 32'd0);
    chk({tag_s, "_alu_B"}, 32'(alu_B), 32'd0);
    chk({tag_s, "_alu_op"}, 32'(alu_op_code), 32'd0);
    chk({tag_s, "_alu_cin"}, 32'(alu_C_in), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;
    int seen;

    repeat (3) @(posedge CLk);
    #1;
    check_reset_outputs("rst");
    Reset_n = 1'b1;
    @(posedge CLk); #1;

    // ADD with carry: 200+100+1 = 0x12D, carry out of bit 7.
    push(4'd0, 8'd200, 8'd100, 1'b1, 4'd3);
    wait_rsp(lat);
    chk("add_latency", 32'(lat), 32'd3);
    chk("add_result", 32'(rsp_result), 32'h012D);
    chk("add_c_out", 32'(rsp_c_out), 32'd1);
    chk("add_z", 32'(rsp_z), 32'd0);
    chk("add_err", 32'(rsp_err), 32'd0);
    chk("add_tag", 32'(rsp_tag), 32'd3);
    @(posedge CLk); #1;

    // SUB underflow wraps; stale ALU carry must not leak out.
    push(4'd1, 8'd5, 8'd7, 1'b0, 4'd4);
    wait_rsp(lat);
    chk("sub_result", 32'(rsp_result), 32'hFFFE);
    chk("sub_c_out", 32'(rsp_c_out), 32'd0);
    @(posedge CLk); #1;
    push(4'd5, 8'h5A, 8'h5A, 1'b0, 4'd5);
    wait_rsp(lat);
    chk("xor_result", 32'(rsp_result), 32'd0);
    chk("xor_z", 32'(rsp_z), 32'd1);
    @(posedge CLk); #1;

    // MUL, then rejected DIV by zero and illegal op.
    push(4'd2, 8'd255, 8'd255, 1'b0, 4'd6);
    wait_rsp(lat);
    chk("mul_result", 32'(rsp_result), 32'hFE01);
    @(posedge CLk); #1;
    push(4'd3, 8'd7, 8'd0, 1'b0, 4'd7);
    wait_rsp(lat);
    chk("div0_latency", 32'(lat), 32'd1);
    chk("div0_err", 32'(rsp_err), 32'd1);
    chk("div0_result", 32'(rsp_result), 32'd0);
    chk("div0_z", 32'(rsp_z), 32'd1);
    chk("div0_tag", 32'(rsp_tag), 32'd7);
    chk("div0_alu_op_held", 32'(alu_op_code), 32'd2);
    chk("div0_alu_a_held", 32'(alu_A), 32'd255);
    @(posedge CLk); #1;
    push(4'd9, 8'd1, 8'd2, 1'b0, 4'd8);
    wait_rsp(lat);
    chk("op9_err", 32'(rsp_err), 32'd1);
    @(posedge CLk); #1;

    // Back-pressure: one in flight plus DEPTH queued.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 4'd4; cmd_a = 8'(i * 37 + 1); cmd_b = 8'hF3; cmd_cin = 1'b0; cmd_tag = 4'(i);
      if (cmd_ready) acc++;
      @(posedge CLk); #1;
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(lat);
      chk("bp_drain_tag", 32'(rsp_tag), 32'(k));
      if (k > 0) chk("bp_gap", 32'(lat), 32'd2);
      @(posedge CLk); #1;
    end

    // Reset during SAMPLE with three commands still queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 4'd0; cmd_a = 8'(i + 10); cmd_b = 8'd1; cmd_cin = 1'b0; cmd_tag = 4'(i + 8);
      @(posedge CLk); #1;
    end
    cmd_valid = 1'b0;
    wait_rsp(lat);
    rsp_ready = 1'b1;
    @(posedge CLk); #1;
    rsp_ready = 1'b0;
    @(posedge CLk); #1;
    chk("pre_rst_alu_A", 32'(alu_A), 32'd11);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge CLk);
    #1;
    Reset_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge CLk); #1;
      if (rsp_valid) seen++;
    end
    chk("post_rst_no_rsp", 32'(seen), 32'd0);

    // Fresh traffic after reset: four issued, two rejected.
    push(4'd0, 8'd1, 8'd2, 1'b0, 4'd1);
    push(4'd7, 8'd1, 8'd2, 1'b0, 4'd2);
    push(4'd1, 8'd9, 8'd3, 1'b0, 4'd3);
    push(4'd3, 8'd9, 8'd0, 1'b0, 4'd4);
    push(4'd2, 8'd12, 8'd12, 1'b0, 4'd5);
    push(4'd5, 8'hFF, 8'h0F, 1'b0, 4'd6);
    repeat (30) @(posedge CLk);
    #1;
    chk("post_rst_drained", 32'(exp_q.size()), 32'd0);
`ifdef ALU_SEQ_STATS_EN
    chk("stat_issued", 32'(stat_issued), 32'd4);
    chk("stat_errors", 32'(stat_errors), 32'd2);
`endif

    // Randomised traffic with random response back-pressure.
    for (int c = 0; c < 800; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 4'($urandom_range(0, 7));
      cmd_a     = 8'($urandom);
      cmd_b     = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      cmd_cin   = 1'($urandom);
      cmd_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge CLk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (40) @(posedge CLk);
    #1;
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_idle_valid", 32'(rsp_valid), 32'd0);
    chk("rand_idle_ready", 32'(cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
